// File: rtl/mac_pkg.sv
// Shared MAC datapath definitions: default data width and occupancy counter sizing.
package mac_pkg;

  localparam int unsigned DATA_W = 8;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: valid bit plus data register with load and clear.
module pipe_stage
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_v,
  output logic [WIDTH-1:0] o_q
);

  logic             r_v;
  logic [WIDTH-1:0] r_q;

  // Clear only drops the valid bit; data is left as-is since it is don't-care once invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= 1'b0;
      r_q <= '0;
    end else if (i_clear) begin
      r_v <= 1'b0;
    end else if (i_load) begin
      r_v <= 1'b1;
      r_q <= i_d;
    end
  end

  assign o_v = r_v;
  assign o_q = r_q;

endmodule

// File: rtl/register_pipe.sv
// Elastic WIDTH x DEPTH register pipeline with collapsing bubbles and occupancy count.
// Optional synchronous flush port enabled by defining REGISTER_PIPE_FLUSH_EN.
module register_pipe
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out,
`ifdef REGISTER_PIPE_FLUSH_EN
  input  logic                     flush,
`endif
  output logic [cnt_w(DEPTH)-1:0]  count
);

  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [DEPTH:0]   w_rdy;
  logic [DEPTH-1:0] w_v;
  logic [DEPTH-1:0] w_up_v;
  logic [DEPTH-1:0] w_load;
  logic [DEPTH-1:0] w_clear;
  logic [WIDTH-1:0] w_q    [DEPTH];
  logic [WIDTH-1:0] w_up_d [DEPTH];
  logic             w_flush;
  logic             w_accept;
  logic             w_deliver;
  logic [CNT_W-1:0] r_count;

`ifdef REGISTER_PIPE_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign w_up_v[i] = in_valid;
      assign w_up_d[i] = in;
    end else begin : g_body
      assign w_up_v[i] = w_v[i-1];
      assign w_up_d[i] = w_q[i-1];
    end

    // Closed form of the ready ripple: ready if any stage from here on is empty, or sink ready.
    assign w_rdy[i]   = out_ready || !(&w_v[DEPTH-1:i]);
    assign w_load[i]  = w_up_v[i] && w_rdy[i] && !w_flush;
    assign w_clear[i] = w_flush || (w_v[i] && w_rdy[i+1] && !(w_up_v[i] && w_rdy[i]));

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (reset),
      .i_load  (w_load[i]),
      .i_clear (w_clear[i]),
      .i_d     (w_up_d[i]),
      .o_v     (w_v[i]),
      .o_q     (w_q[i])
    );
  end

  assign in_ready  = w_rdy[0] && !w_flush;
  assign out_valid = w_v[DEPTH-1] && !w_flush;
  assign out       = w_q[DEPTH-1];
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = out_valid && out_ready;

  // Occupancy tracks accepted minus delivered beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (w_flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_deliver);
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_register_pipe.sv
// Bench for register_pipe: DEPTH=2 and DEPTH=3 instances against a timestamped FIFO model.
module tb_register_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] din = 8'h00;

  logic [1:0] ir;
  logic [1:0] ov;
  logic [7:0] o [2];
  logic [1:0] c [2];

  int n_cmp = 0;
  int n_err = 0;

  // Model: per instance a FIFO of beats, each with the edge from which it may sit on out.
  logic [7:0] md [2][4];
  int         mr [2][4];
  int         mh [2];
  int         ms [2];
  int         edge_n = 0;

  always #5 clk = ~clk;

  register_pipe #(.WIDTH(8), .DEPTH(2)) u_d2 (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (ir[0]),
    .in        (din),
    .out_valid (ov[0]),
    .out_ready (out_ready),
    .out       (o[0]),
`ifdef REGISTER_PIPE_FLUSH_EN
    .flush     (flush),
`endif
    .count     (c[0])
  );

  register_pipe #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (ir[1]),
    .in        (din),
    .out_valid (ov[1]),
    .out_ready (out_ready),
    .out       (o[1]),
`ifdef REGISTER_PIPE_FLUSH_EN
    .flush     (flush),
`endif
    .count     (c[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, got, exp, edge_n);
    end
  endtask

  function automatic int dep(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic logic exp_ready(input int k);
    return !flush && ((ms[k] < dep(k)) || out_ready);
  endfunction

  function automatic logic exp_valid(input int k);
    return !flush && (ms[k] > 0) && (edge_n >= mr[k][mh[k]]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ms[k] = 0;
      mh[k] = 0;
    end
  endtask

  // Check one cycle at the current inputs, advance one edge, update the model.
  task automatic step();
    logic [1:0] er, ev, acc, del;
    int idx;
    #1;
    for (int k = 0; k < 2; k++) begin
      er[k]  = exp_ready(k);
      ev[k]  = exp_valid(k);
      acc[k] = in_valid && er[k];
      del[k] = ev[k] && out_ready;
      chk($sformatf("in_ready[d%0d]", dep(k)), 32'(ir[k]), 32'(er[k]));
      chk($sformatf("out_valid[d%0d]", dep(k)), 32'(ov[k]), 32'(ev[k]));
      chk($sformatf("count[d%0d]", dep(k)), 32'(c[k]), 32'(ms[k]));
      if (ev[k]) chk($sformatf("out[d%0d]", dep(k)), 32'(o[k]), 32'(md[k][mh[k]]));
    end
    @(posedge clk);
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      if (flush) begin
        ms[k] = 0;
      end else begin
        if (del[k]) begin
          mh[k] = (mh[k] + 1) % 4;
          ms[k]--;
          if (ms[k] > 0 && mr[k][mh[k]] < edge_n) mr[k][mh[k]] = edge_n;
        end
        if (acc[k]) begin
          idx = (mh[k] + ms[k]) % 4;
          md[k][idx] = din;
          mr[k][idx] = edge_n + dep(k) - 1;
          ms[k]++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
    in_valid  = v;
    din       = d;
    out_ready = r;
    flush     = f;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", 32'(ov[k]), 32'd0);
      chk("rst_count", 32'(c[k]), 32'd0);
      chk("rst_out", 32'(o[k]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Unobstructed stream 0x01..0x10
    for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill under backpressure, hold, then drain (includes full with simultaneous accept/deliver)
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Bubble collapse
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset mid-stream
    in_valid = 1'b1; din = 8'h44; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("midrst_out_valid", 32'(ov[k]), 32'd0);
      chk("midrst_count", 32'(c[k]), 32'd0);
      chk("midrst_out", 32'(o[k]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h9E, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef REGISTER_PIPE_FLUSH_EN
    // Flush with a beat offered: nothing accepted, flushed beats never emerge
    drive(1'b1, 8'hF1, 1'b0, 1'b0);
    drive(1'b1, 8'hF2, 1'b0, 1'b0);
    drive(1'b1, 8'hF3, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 8'h3C, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
`endif

    // Randomized traffic with drifting backpressure
    for (int i = 0; i < 600; i++) begin
      int  bias;
      logic f;
      bias = (i / 50) % 4;
      f = 1'b0;
`ifdef REGISTER_PIPE_FLUSH_EN
      f = ($urandom_range(0, 31) == 0);
`endif
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) <= bias, f);
    end
    for (int i = 0; i < 6; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/register_pipe.md
# register_pipe

Parametrised elastic pipeline register for the MAC datapath: a WIDTH-bit, DEPTH-stage register chain with a per-stage valid bit and valid/ready handshake at both ends. Replaces fixed-width operand/result registers between the multiplier, adder and accumulator. Bubbles collapse under backpressure, so a stalled consumer never causes data loss. An occupancy count feeds the MAC controller.

## Interface
Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 2, number of register stages (>=1)

Ports:
- clk  input  1  rising-edge clock; the block's only clock
- reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately
- in_valid  input  1  upstream has a beat on in
- in_ready  output  1  block accepts the beat this cycle
- in  input  WIDTH  upstream data
- out_valid  output  1  stage DEPTH-1 holds a beat
- out_ready  input  1  downstream accepts the beat this cycle
- out  output  WIDTH  data of stage DEPTH-1
- count  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH
- flush  input  1  synchronous pipeline clear (present only with REGISTER_PIPE_FLUSH_EN)

## Operation
- Stages 0..DEPTH-1; stage 0 fed by in, stage DEPTH-1 drives out/out_valid.
- Define rdy[DEPTH] = out_ready; rdy[i] = !v[i] || rdy[i+1]; in_ready = rdy[0].
- Stage i loads when upstream valid (in_valid for i=0, v[i-1] otherwise) and rdy[i]; it then takes upstream data and sets v[i]=1.
- Stage i empties (v[i]=0) when v[i] && rdy[i+1] and it does not load in the same cycle.
- Otherwise stage holds data and valid unchanged.
- Accept = in_valid && in_ready; deliver = out_valid && out_ready.
- count next = count + accept - deliver; never exceeds DEPTH, never wraps below 0.
- out is stable while out_valid && !out_ready.
- in_valid && !in_ready: in is ignored; upstream holds.
- Data in an invalid stage is don't-care for out; out_valid is authoritative.

## Timing
- Reset (reset=0): all v[i]=0, all data=0, count=0, out=0, out_valid=0; in_ready=1 once reset released (since out_ready path gives rdy=1 for empty stages).
- Latency: beat accepted at edge N appears on out with out_valid=1 after edge N+DEPTH-1 (i.e. DEPTH register stages) when unobstructed.
- Throughput: one beat per cycle sustained with out_ready=1.
- Full (count=DEPTH) and out_ready=0: in_ready=0. Full with out_ready=1: simultaneous accept and deliver, count unchanged.
- in_ready is combinational from out_ready (ripple through v[]); documented path, no registered ready.
- Reset asserted mid-stream: all beats discarded asynchronously; no output beat after release until new input propagates.

## Configuration
- REGISTER_PIPE_FLUSH_EN defined: flush port exists. flush=1 at an edge clears all v[i] and count to 0; data registers keep values. During a flush cycle in_ready=0 and out_valid=0 (no accept, no deliver). Flush has priority over all loads; reset has priority over flush.
- Not defined: no flush port; pipeline clears only via reset.

## Structure
- Shared package mac_pkg: DATA_W default (8), function cnt_w(depth) = $clog2(depth+1).
- Sub-module pipe_stage: one valid bit plus WIDTH-bit data register with async active-low reset, load and clear inputs; register_pipe instantiates DEPTH of them via generate.

## Test plan
- Reset then stream 0x01..0x10, WIDTH=8, DEPTH=2, out_ready=1 -> out 0x01 valid 2 cycles after first accept, one beat per cycle, count steady at 2.
- Fill with out_ready=0: send 0xA5,0x5A -> count=2, in_ready=0, out=0xA5 held stable; raise out_ready -> 0xA5 then 0x5A delivered in order, count 2->1->0.
- Bubble collapse, DEPTH=3: beat 0x11, gap, 0x22, out_ready=0 -> both packed, count=2, in_ready=1 for third beat 0x33 -> count=3.
- Assert reset mid-stream with count=2 -> out_valid=0, out=0, count=0 immediately; after release, first output is next new beat.
- Full with out_ready=1 and in_valid=1 same cycle -> accept and deliver together, count unchanged, no beat lost (scoreboard).
- With REGISTER_PIPE_FLUSH_EN: count=2, flush=1 with in_valid=1 -> in_ready=0, out_valid=0, next cycle count=0, flushed beats never appear.
